// File: rtl/imm_instr_encoder_pkg.sv
// Shared RV32I encodings used by the immediate encoder, generator and decoder.
package imm_instr_encoder_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'd3;
    localparam logic [6:0] OPC_STORE  = 7'd35;
    localparam logic [6:0] OPC_BRANCH = 7'd99;

    typedef enum logic [1:0] {
        KIND_LOAD   = 2'd0,
        KIND_STORE  = 2'd1,
        KIND_BRANCH = 2'd2,
        KIND_RSVD   = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_KIND  = 2'd1,
        ERR_RANGE = 2'd2,
        ERR_ALIGN = 2'd3
    } err_e;

    typedef struct packed {
        kind_e       kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [31:0] imm;
    } cmd_t;

endpackage

// File: rtl/imm_instr_encoder_imm_pack.sv
// Packs one command into a LOAD/STORE/BRANCH word and grades its immediate.
// Latency: combinational.
// Backpressure: none; pure function of the command.
module imm_pack
    import imm_instr_encoder_pkg::*;
(
    input  cmd_t        cmd,
    output logic [31:0] instr,
    output err_e        err
);

    logic signed [31:0] simm;
    logic [31:0]        imm;

    assign imm  = cmd.imm;
    assign simm = cmd.imm;

    always_comb begin
        instr = '0;
        err   = ERR_NONE;
        case (cmd.kind)
            KIND_LOAD: begin
                instr = {imm[11:0], cmd.rs1, cmd.funct3, cmd.rd, OPC_LOAD};
                if (simm < -32'sd2048 || simm > 32'sd2047) err = ERR_RANGE;
            end
            KIND_STORE: begin
                instr = {imm[11:5], cmd.rs2, cmd.rs1, cmd.funct3, imm[4:0], OPC_STORE};
                if (simm < -32'sd2048 || simm > 32'sd2047) err = ERR_RANGE;
            end
            KIND_BRANCH: begin
                instr = {imm[12], imm[10:5], cmd.rs2, cmd.rs1, cmd.funct3,
                         imm[4:1], imm[11], OPC_BRANCH};
                // Range is checked first so an odd out-of-range offset reports RANGE.
                if (simm < -32'sd4096 || simm > 32'sd4094) err = ERR_RANGE;
                else if (imm[0])                           err = ERR_ALIGN;
            end
            default: err = ERR_KIND;
        endcase
    end

endmodule

// File: rtl/imm_instr_encoder.sv
// Encodes LOAD/STORE/BRANCH commands into addressed instruction words with error status.
// Latency: one cycle from accept to out_*; one word per cycle sustained.
// Backpressure: in_ready follows out_ready through the output register; low during addr_load.
module imm_instr_encoder
    import imm_instr_encoder_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_kind,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [ADDR_W-1:0]    out_addr,
    input  logic                 addr_load,
    input  logic [ADDR_W-1:0]    addr_value,
    input  logic                 err_clr,
    output logic                 err_flag,
    output logic [1:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    cmd_t              cmd;
    logic [31:0]       enc_instr;
    err_e              enc_err;
    logic              accept;
    logic              legal;
    logic [ADDR_W-1:0] addr_cnt;

    always_comb begin
        cmd        = '0;
        cmd.kind   = kind_e'(in_kind);
        cmd.rd     = in_rd;
        cmd.rs1    = in_rs1;
        cmd.rs2    = in_rs2;
        cmd.funct3 = in_funct3;
        cmd.imm    = in_imm;
    end

    imm_pack u_imm_pack (
        .cmd   (cmd),
        .instr (enc_instr),
        .err   (enc_err)
    );

    assign in_ready = !addr_load && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign legal    = (enc_err == ERR_NONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= BASE_ADDR;
            addr_cnt  <= BASE_ADDR;
        end else begin
            if (accept && legal) begin
                out_valid <= 1'b1;
                out_instr <= enc_instr;
                out_addr  <= addr_cnt;
                addr_cnt  <= addr_cnt + ADDR_W'(4);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // in_ready is low during a reload, so this never races the increment.
            if (addr_load) addr_cnt <= addr_value;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag <= 1'b0;
            err_code <= ERR_NONE;
            err_cnt  <= '0;
        end else if (accept && !legal) begin
            err_flag <= 1'b1;
            if (!err_flag || err_clr) err_code <= enc_err;
            if (err_clr)              err_cnt  <= ERR_CNT_W'(1);
            else if (!(&err_cnt))     err_cnt  <= err_cnt + ERR_CNT_W'(1);
        end else if (err_clr) begin
            err_flag <= 1'b0;
            err_code <= ERR_NONE;
            err_cnt  <= '0;
        end
    end

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Bench for imm_instr_encoder: directed plan steps then randomized commands vs a reference model.
module tb_imm_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_kind = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        addr_load = 1'b0;
    logic [31:0] addr_value = '0;
    logic        err_clr = 1'b0;
    logic        err_flag;
    logic [1:0]  err_code;
    logic [7:0]  err_cnt;

    imm_instr_encoder #(.ADDR_W(32), .BASE_ADDR(BASE), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .addr_load(addr_load), .addr_value(addr_value), .err_clr(err_clr),
        .err_flag(err_flag), .err_code(err_code), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: what a reader of the spec expects on the outputs.
    logic        m_vld;
    logic [31:0] m_instr, m_addr, m_cnt;
    logic        m_flag;
    logic [1:0]  m_code;
    int          m_ecnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [1:0] kind, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [2:0] f3, input int imm);
        int unsigned u, r1, r2, d, f, w;
        u = imm; r1 = rs1; r2 = rs2; d = rd; f = f3;
        w = (r1 << 15) | (f << 12);
        case (kind)
            2'd0: w = w | ((u & 32'hFFF) << 20) | (d << 7) | 3;
            2'd1: w = w | (((u >> 5) & 127) << 25) | (r2 << 20) | ((u & 31) << 7) | 35;
            2'd2: w = w | (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (r2 << 20)
                        | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | 99;
            default: w = 0;
        endcase
        return w;
    endfunction

    function automatic int ref_code(input logic [1:0] kind, input int imm);
        if (kind == 2'd3) return 1;
        if (kind == 2'd2) begin
            if (imm < -4096 || imm > 4094) return 2;
            if ((imm & 1) != 0) return 3;
            return 0;
        end
        if (imm < -2048 || imm > 2047) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_vld = 1'b0; m_instr = '0; m_addr = BASE; m_cnt = BASE;
        m_flag = 1'b0; m_code = 2'd0; m_ecnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_vld));
        chk({tag, ".out_instr"}, out_instr, m_instr);
        chk({tag, ".out_addr"},  out_addr,  m_addr);
        chk({tag, ".err_flag"},  32'(err_flag), 32'(m_flag));
        chk({tag, ".err_code"},  32'(err_code), 32'(m_code));
        chk({tag, ".err_cnt"},   32'(err_cnt),  m_ecnt);
    endtask

    // One cycle: drive at posedge+1, check in_ready, clock, check outputs at posedge+1.
    task automatic apply(input string tag, input logic vld, input logic [1:0] kind,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3, input int imm, input logic ordy,
                         input logic aload, input logic [31:0] aval, input logic eclr);
        logic rdy_exp, acc;
        int   code;
        in_valid = vld; in_kind = kind; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_imm = imm; out_ready = ordy; addr_load = aload;
        addr_value = aval; err_clr = eclr;
        #1;
        rdy_exp = !aload && (!m_vld || ordy);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy_exp));
        acc  = vld && rdy_exp;
        code = ref_code(kind, imm);
        @(posedge clk);
        #1;
        if (acc && code == 0) begin
            m_vld = 1'b1; m_instr = ref_word(kind, rd, rs1, rs2, f3, imm);
            m_addr = m_cnt; m_cnt = m_cnt + 32'd4;
        end else if (ordy) begin
            m_vld = 1'b0;
        end
        if (aload) m_cnt = aval;
        if (acc && code != 0) begin
            if (!m_flag || eclr) m_code = 2'(code);
            m_ecnt = eclr ? 1 : (m_ecnt == 255 ? 255 : m_ecnt + 1);
            m_flag = 1'b1;
        end else if (eclr) begin
            m_flag = 1'b0; m_code = 2'd0; m_ecnt = 0;
        end
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input logic ordy);
        apply(tag, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 0, ordy, 1'b0, 32'd0, 1'b0);
    endtask

    int imm_edges [12] = '{-4097, -4096, -4095, -2049, -2048, -1, 0, 2047, 2048, 4094, 4095, 4096};

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst_n = 1'b1;

        apply("load", 1'b1, 2'd0, 5'd5, 5'd2, 5'd0, 3'd2, -4, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("load.const", out_instr, 32'hFFC12283);
        chk("load.addr", out_addr, BASE);

        apply("store", 1'b1, 2'd1, 5'd0, 5'd2, 5'd6, 3'd2, 8, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("store.const", out_instr, 32'h00612423);
        apply("branch", 1'b1, 2'd2, 5'd0, 5'd1, 5'd2, 3'd0, 16, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("branch.const", out_instr, 32'h00208863);
        chk("branch.addr", out_addr, BASE + 32'd8);

        apply("br_min", 1'b1, 2'd2, 5'd0, 5'd0, 5'd0, 3'd0, -4096, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("br_min.const", out_instr, 32'h80000063);
        apply("br_odd", 1'b1, 2'd2, 5'd0, 5'd0, 5'd0, 3'd0, 3, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("br_odd.code", 32'(err_code), 32'd3);

        apply("clr", 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 0, 1'b1, 1'b0, 32'd0, 1'b1);
        apply("ld_range", 1'b1, 2'd0, 5'd1, 5'd1, 5'd0, 3'd0, 2048, 1'b1, 1'b0, 32'd0, 1'b0);
        apply("rsvd", 1'b1, 2'd3, 5'd1, 5'd1, 5'd1, 3'd0, 0, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("rsvd.code_kept", 32'(err_code), 32'd2);
        chk("rsvd.cnt", 32'(err_cnt), 32'd2);
        apply("clr_err", 1'b1, 2'd3, 5'd0, 5'd0, 5'd0, 3'd0, 0, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("clr_err.code", 32'(err_code), 32'd1);
        chk("clr_err.cnt", 32'(err_cnt), 32'd1);

        apply("pend", 1'b1, 2'd0, 5'd3, 5'd4, 5'd0, 3'd1, 100, 1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++)
            apply("stall", 1'b1, 2'd0, 5'd7, 5'd7, 5'd0, 3'd7, -100, 1'b0, 1'b0, 32'd0, 1'b0);
        apply("reload", 1'b1, 2'd0, 5'd7, 5'd7, 5'd0, 3'd7, -100, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        apply("wrap0", 1'b1, 2'd0, 5'd1, 5'd2, 5'd0, 3'd0, 1, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("wrap0.addr", out_addr, 32'hFFFF_FFFC);
        apply("wrap1", 1'b1, 2'd0, 5'd1, 5'd2, 5'd0, 3'd0, 2, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("wrap1.addr", out_addr, 32'h0000_0000);

        for (int i = 0; i < 400; i++) begin
            int          imm;
            logic [1:0]  kind;
            kind = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       imm = int'($urandom_range(0, 9000)) - 4500;
                1:       imm = imm_edges[$urandom_range(0, 11)];
                2:       imm = int'($urandom);
                default: imm = (int'($urandom_range(0, 4000)) - 2000) * 2;
            endcase
            apply("rand", $urandom_range(0, 4) != 0, kind, 5'($urandom), 5'($urandom),
                  5'($urandom), 3'($urandom), imm, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 15) == 0);
        end

        apply("pre_rst", 1'b1, 2'd1, 5'd0, 5'd9, 5'd8, 3'd3, -8, 1'b1, 1'b0, 32'd0, 1'b0);
        apply("pre_rst_err", 1'b1, 2'd3, 5'd0, 5'd0, 5'd0, 3'd0, 0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("pre_rst.vld", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        apply("post_rst", 1'b1, 2'd0, 5'd5, 5'd2, 5'd0, 3'd2, -4, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("post_rst.addr", out_addr, BASE);
        idle("drain", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
